// File: rtl/aes_pkg.sv
// Shared AES-128 sizes, controller state type and GF(2^8) helpers
// used by the key-schedule sequencer and its expander.
package aes_pkg;

  localparam int AES_NR    = 10;
  localparam int AES_NRK   = 11;
  localparam int AES_KEY_W = 128;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    EXPAND
  } state_t;

  typedef logic [3:0] rnd_t;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a,
                                        input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // S-box as a^254 (field inverse, 0 -> 0) followed by the affine map.
  function automatic logic [7:0] aes_sbox(input logic [7:0] a);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv
         ^ {inv[6:0], inv[7]}
         ^ {inv[5:0], inv[7:6]}
         ^ {inv[4:0], inv[7:5]}
         ^ {inv[3:0], inv[7:4]}
         ^ 8'h63;
  endfunction

endpackage

// File: rtl/aes_key_expand_128.sv
// AES-128 key expander: start_flag loads the cipher key, then each
// cycle the word outputs advance by one round key.
module aes_key_expand_128
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 start_flag,
  input  logic [AES_KEY_W-1:0] key,
  output logic [31:0]          wo_0,
  output logic [31:0]          wo_1,
  output logic [31:0]          wo_2,
  output logic [31:0]          wo_3
);

  logic [31:0] r_w0;
  logic [31:0] r_w1;
  logic [31:0] r_w2;
  logic [31:0] r_w3;
  logic [7:0]  r_rcon;

  logic [31:0] w_rot;
  logic [31:0] w_t;
  logic [31:0] w_n0;
  logic [31:0] w_n1;
  logic [31:0] w_n2;
  logic [31:0] w_n3;

  assign w_rot = {r_w3[23:0], r_w3[31:24]};
  assign w_t   = {aes_sbox(w_rot[31:24]) ^ r_rcon,
                  aes_sbox(w_rot[23:16]),
                  aes_sbox(w_rot[15:8]),
                  aes_sbox(w_rot[7:0])};

  assign w_n0 = r_w0 ^ w_t;
  assign w_n1 = r_w1 ^ w_n0;
  assign w_n2 = r_w2 ^ w_n1;
  assign w_n3 = r_w3 ^ w_n2;

  // No reset: the sequencer always pulses start_flag before capturing.
  always_ff @(posedge clk) begin
    if (start_flag) begin
      r_w0   <= key[127:96];
      r_w1   <= key[95:64];
      r_w2   <= key[63:32];
      r_w3   <= key[31:0];
      r_rcon <= 8'h01;
    end else begin
      r_w0   <= w_n0;
      r_w1   <= w_n1;
      r_w2   <= w_n2;
      r_w3   <= w_n3;
      r_rcon <= xtime(r_rcon);
    end
  end

  assign wo_0 = r_w0;
  assign wo_1 = r_w1;
  assign wo_2 = r_w2;
  assign wo_3 = r_w3;

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-schedule sequencer: accepts a key, runs the expander and
// holds all 11 round keys in a buffer with a registered read port.
module aes_key_sched_ctrl
  import aes_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 key_valid,
  input  logic [AES_KEY_W-1:0] key,
  output logic                 key_ready,
  input  logic                 key_clear,
  output logic                 busy,
  output logic                 keys_valid,
  input  logic [3:0]           rk_addr,
  output logic [AES_KEY_W-1:0] rk_data
);

  state_t               r_state;
  rnd_t                 r_rnd;
  logic [AES_KEY_W-1:0] r_key_q;
  logic [AES_KEY_W-1:0] r_buf [AES_NRK];
  logic                 r_key_ready;
  logic                 r_busy;
  logic                 r_keys_valid;
  logic [AES_KEY_W-1:0] r_rk_data;

  logic                 w_start;
  logic [31:0]          w_wo0;
  logic [31:0]          w_wo1;
  logic [31:0]          w_wo2;
  logic [31:0]          w_wo3;
  logic [AES_KEY_W-1:0] w_rk;
  logic [AES_KEY_W-1:0] w_rd;

  assign w_start = (r_state == LOAD);
  assign w_rk    = {w_wo0, w_wo1, w_wo2, w_wo3};

  aes_key_expand_128 u_expand (
    .clk        (clk),
    .start_flag (w_start),
    .key        (r_key_q),
    .wo_0       (w_wo0),
    .wo_1       (w_wo1),
    .wo_2       (w_wo2),
    .wo_3       (w_wo3)
  );

  // Indexes 11..15 match no entry and read as zero.
  always_comb begin
    w_rd = '0;
    for (int i = 0; i < AES_NRK; i++) begin
      if (rk_addr == 4'(i)) w_rd = r_buf[i];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || key_clear) begin
      r_state      <= IDLE;
      r_rnd        <= '0;
      r_key_q      <= '0;
      r_key_ready  <= 1'b1;
      r_busy       <= 1'b0;
      r_keys_valid <= 1'b0;
      r_rk_data    <= '0;
      for (int i = 0; i < AES_NRK; i++) r_buf[i] <= '0;
    end else begin
      r_rk_data <= w_rd;
      unique case (r_state)
        IDLE: begin
          if (key_valid && r_key_ready) begin
            r_key_q      <= key;
            r_keys_valid <= 1'b0;
            r_key_ready  <= 1'b0;
            r_busy       <= 1'b1;
            r_state      <= LOAD;
          end
        end
        LOAD: begin
          r_rnd   <= '0;
          r_state <= EXPAND;
        end
        EXPAND: begin
          for (int i = 0; i < AES_NRK; i++) begin
            if (r_rnd == 4'(i)) r_buf[i] <= w_rk;
          end
          if (r_rnd == 4'(AES_NR)) begin
            r_rnd        <= '0;
            r_keys_valid <= 1'b1;
            r_key_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_state      <= IDLE;
          end else begin
            r_rnd <= r_rnd + 4'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign key_ready  = r_key_ready;
  assign busy       = r_busy;
  assign keys_valid = r_keys_valid;
  assign rk_data    = r_rk_data;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Bench for aes_key_sched_ctrl: FIPS-197 vectors plus random keys
// checked against a table-driven key expansion model.
module tb_aes_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         key_valid;
  logic [127:0] key;
  logic         key_ready;
  logic         key_clear;
  logic         busy;
  logic         keys_valid;
  logic [3:0]   rk_addr;
  logic [127:0] rk_data;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]   sb [256];
  logic [7:0]   rc [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                            8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  logic [127:0] exp_rk [11];

  aes_key_sched_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_valid  (key_valid),
    .key        (key),
    .key_ready  (key_ready),
    .key_clear  (key_clear),
    .busy       (busy),
    .keys_valid (keys_valid),
    .rk_addr    (rk_addr),
    .rk_data    (rk_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // S-box from the generator-3 walk over the multiplicative group.
  task automatic build_sbox;
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b00};
      q = q ^ {q[3:0], 4'h0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]}
            ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] t;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
        t = t ^ {rc[i/4 - 1], 24'h0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++)
      exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic rd(input logic [3:0] a, output logic [127:0] d);
    rk_addr = a;
    tick();
    d = rk_data;
  endtask

  task automatic do_accept(input logic [127:0] k);
    key       = k;
    key_valid = 1'b1;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic wait_kv(output int n);
    n = 0;
    while (!keys_valid && n < 30) begin
      tick();
      n++;
    end
  endtask

  task automatic check_all_model(input string tag);
    logic [127:0] d;
    int order [11];
    int j, tmp;
    for (int i = 0; i < 11; i++) order[i] = i;
    for (int i = 10; i > 0; i--) begin
      j = $urandom_range(i, 0);
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    for (int pass = 0; pass < 2; pass++)
      for (int i = 0; i < 11; i++) begin
        rd(4'(order[i]), d);
        n_cmp++;
        if (d !== exp_rk[order[i]]) begin
          n_bad++;
          $display("FAIL %s rk[%0d]: got %h want %h",
                   tag, order[i], d, exp_rk[order[i]]);
        end
      end
  endtask

  task automatic check_all_zero(input string tag);
    logic [127:0] d;
    for (int i = 0; i < 11; i++) begin
      rd(4'(i), d);
      n_cmp++;
      if (d !== '0) begin
        n_bad++;
        $display("FAIL %s rk[%0d]: got %h want 0", tag, i, d);
      end
    end
  endtask

  task automatic check_idle_zero(input string tag);
    n_cmp++;
    if ({key_ready, busy, keys_valid} !== 3'b100 || rk_data !== '0) begin
      n_bad++;
      $display("FAIL %s: ready/busy/kv=%b%b%b rk_data=%h want 100 and 0",
               tag, key_ready, busy, keys_valid, rk_data);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    key_valid = 1'b0;
    key_clear = 1'b0;
    key = '0;
    rk_addr = '0;
    tick();
    tick();
    rst_n = 1'b1;
    check_idle_zero("reset_state");
    check_all_zero("reset_buf");
  endtask

  task automatic test_fips;
    logic [127:0] d;
    int n;
    model_expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
    do_accept(128'h2b7e151628aed2a6abf7158809cf4f3c);
    n_cmp++;
    if (busy !== 1'b1 || key_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL fips_load: busy=%b ready=%b want 1 0", busy, key_ready);
    end
    wait_kv(n);
    n_cmp++;
    if (n !== 12) begin
      n_bad++;
      $display("FAIL fips_latency: kv after %0d cycles want 13", n + 1);
    end
    rd(4'd0, d);
    n_cmp++;
    if (d !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin
      n_bad++;
      $display("FAIL fips_rk0: got %h", d);
    end
    rd(4'd1, d);
    n_cmp++;
    if (d !== 128'ha0fafe1788542cb123a339392a6c7605) begin
      n_bad++;
      $display("FAIL fips_rk1: got %h", d);
    end
    rd(4'd10, d);
    n_cmp++;
    if (d !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
      n_bad++;
      $display("FAIL fips_rk10: got %h", d);
    end
    check_all_model("fips_model");
  endtask

  task automatic test_back_to_back;
    logic [127:0] d;
    int n;
    int bad_rdy;
    do_accept({$urandom, $urandom, $urandom, $urandom});
    key = '0;
    key_valid = 1'b1;
    bad_rdy = 0;
    for (int i = 1; i <= 12; i++) begin
      if (key_ready !== 1'b0) bad_rdy++;
      tick();
    end
    n_cmp++;
    if (bad_rdy != 0) begin
      n_bad++;
      $display("FAIL b2b_holdoff: ready high in %0d busy cycles want 0",
               bad_rdy);
    end
    n_cmp++;
    if (key_ready !== 1'b1 || keys_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL b2b_a13: ready=%b kv=%b want 1 1", key_ready, keys_valid);
    end
    tick();
    key_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b1 || keys_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL b2b_accept2: busy=%b kv=%b want 1 0", busy, keys_valid);
    end
    model_expand('0);
    wait_kv(n);
    n_cmp++;
    if (n !== 12) begin
      n_bad++;
      $display("FAIL b2b_latency: kv after %0d cycles want 13", n + 1);
    end
    rd(4'd10, d);
    n_cmp++;
    if (d !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin
      n_bad++;
      $display("FAIL b2b_zero_rk10: got %h", d);
    end
    check_all_model("b2b_model");
  endtask

  task automatic test_clear_mid;
    logic [127:0] k;
    int n;
    int bad_kv;
    do_accept({$urandom, $urandom, $urandom, $urandom});
    for (int i = 0; i < 6; i++) tick();
    key_clear = 1'b1;
    tick();
    key_clear = 1'b0;
    check_idle_zero("clear_mid");
    bad_kv = 0;
    for (int i = 0; i < 15; i++) begin
      tick();
      if (keys_valid !== 1'b0 || busy !== 1'b0) bad_kv++;
    end
    n_cmp++;
    if (bad_kv != 0) begin
      n_bad++;
      $display("FAIL clear_stays_idle: %0d cycles kv/busy high want 0", bad_kv);
    end
    check_all_zero("clear_buf");
    k = {$urandom, $urandom, $urandom, $urandom};
    model_expand(k);
    do_accept(k);
    wait_kv(n);
    n_cmp++;
    if (n !== 12) begin
      n_bad++;
      $display("FAIL clear_next_latency: kv after %0d want 13", n + 1);
    end
    check_all_model("clear_next");
  endtask

  task automatic test_clear_vs_accept;
    logic [127:0] k;
    int n;
    k = {$urandom, $urandom, $urandom, $urandom};
    key = k;
    key_valid = 1'b1;
    key_clear = 1'b1;
    tick();
    key_clear = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || key_ready !== 1'b1 || keys_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL clr_prio: busy=%b ready=%b kv=%b want 0 1 0",
               busy, key_ready, keys_valid);
    end
    tick();
    key_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL clr_pending_accept: busy=%b want 1", busy);
    end
    model_expand(k);
    wait_kv(n);
    n_cmp++;
    if (n !== 12) begin
      n_bad++;
      $display("FAIL clr_pending_latency: kv after %0d want 13", n + 1);
    end
    check_all_model("clr_pending");
  endtask

  task automatic test_oob;
    logic [127:0] d;
    for (int a = 11; a < 16; a++) begin
      rd(4'(a), d);
      n_cmp++;
      if (d !== '0) begin
        n_bad++;
        $display("FAIL oob_addr%0d: got %h want 0", a, d);
      end
    end
  endtask

  task automatic test_reset_mid;
    do_accept({$urandom, $urandom, $urandom, $urandom});
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_idle_zero("reset_mid");
    check_all_zero("reset_mid_buf");
  endtask

  task automatic test_random_keys;
    logic [127:0] k;
    int n;
    for (int t = 0; t < 4; t++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      model_expand(k);
      do_accept(k);
      wait_kv(n);
      n_cmp++;
      if (n !== 12) begin
        n_bad++;
        $display("FAIL rand%0d_latency: kv after %0d want 13", t, n + 1);
      end
      check_all_model("rand");
    end
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips();
    test_back_to_back();
    test_clear_mid();
    test_clear_vs_accept();
    test_oob();
    test_reset_mid();
    test_random_keys();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
